// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the pattern generator and checker.
// The step function lives here so both ends always use the same polynomial.
package lfsr_pkg;

    localparam int LFSR_WIDTH = 4;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 4'b1100;
    localparam int LFSR_MAX_W = 32;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } chk_state_t;

    // Fibonacci shift-left step, masked to the active word width.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] q,
        input logic [LFSR_MAX_W-1:0] taps,
        input int width = LFSR_WIDTH
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic fb;
        mask = (LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1);
        fb = ^(q & taps & mask);
        return ((q << 1) | LFSR_MAX_W'(fb)) & mask;
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: seeds from data, verifies a run, then
// flywheels on its own prediction and counts mismatches while locked.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS),
    parameter int LOCK_COUNT = 3,
    parameter int UNLOCK_COUNT = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_count_o
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int UW = $clog2(UNLOCK_COUNT + 1);

    chk_state_t state, state_n;
    logic [WIDTH-1:0] expected, expected_n;
    logic [MW-1:0] match_cnt, match_n, match_inc;
    logic [UW-1:0] miss_cnt, miss_n, miss_inc;
    logic err_q, err_n;
    logic [CNT_W-1:0] err_cnt, cnt_n;
    logic [WIDTH-1:0] nxt_data, nxt_exp;
    logic hit;

    assign nxt_data = WIDTH'(lfsr_next(LFSR_MAX_W'(data_i), LFSR_MAX_W'(TAPS), WIDTH));
    assign nxt_exp = WIDTH'(lfsr_next(LFSR_MAX_W'(expected), LFSR_MAX_W'(TAPS), WIDTH));
    assign hit = (data_i == expected);
    assign match_inc = match_cnt + MW'(1);
    assign miss_inc = miss_cnt + UW'(1);

    always_comb begin
        state_n = state;
        expected_n = expected;
        match_n = match_cnt;
        miss_n = miss_cnt;
        err_n = 1'b0;
        cnt_n = err_cnt;
        if (valid_i) begin
            unique case (state)
                SEARCH: begin
                    if (data_i != '0) begin
                        expected_n = nxt_data;
                        match_n = '0;
                        state_n = VERIFY;
                    end
                end
                VERIFY: begin
                    if (hit) begin
                        match_n = match_inc;
                        expected_n = nxt_data;
                        if (match_inc == MW'(LOCK_COUNT)) begin
                            state_n = LOCKED;
                            miss_n = '0;
                        end
                    end else if (data_i != '0) begin
                        expected_n = nxt_data;
                        match_n = '0;
                    end else begin
                        state_n = SEARCH;
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction never reseeds from received data.
                    expected_n = nxt_exp;
                    if (hit) begin
                        miss_n = '0;
                    end else begin
                        err_n = 1'b1;
                        if (err_cnt != {CNT_W{1'b1}}) begin
                            cnt_n = err_cnt + CNT_W'(1);
                        end
                        miss_n = miss_inc;
                        if (miss_inc == UW'(UNLOCK_COUNT)) begin
                            state_n = SEARCH;
                        end
                    end
                end
                default: state_n = SEARCH;
            endcase
        end
        if (clear_i) begin
            cnt_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SEARCH;
            expected <= '0;
            match_cnt <= '0;
            miss_cnt <= '0;
            err_q <= 1'b0;
            err_cnt <= '0;
        end else begin
            state <= state_n;
            expected <= expected_n;
            match_cnt <= match_n;
            miss_cnt <= miss_n;
            err_q <= err_n;
            err_cnt <= cnt_n;
        end
    end

    assign locked_o = (state == LOCKED);
    assign err_o = err_q;
    assign err_count_o = err_cnt;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: default instance plus a
// narrow-counter instance for saturation.
module tb_lfsr_checker;

    typedef struct packed {
        logic l;
        logic e;
        logic [15:0] c;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;
    logic valid_i = 1'b0;
    logic [3:0] data_i = 4'h0;
    logic clear_i = 1'b0;
    logic locked_o;
    logic err_o;
    logic [15:0] err_count_o;

    logic s_reset = 1'b0;
    logic s_valid = 1'b0;
    logic [3:0] s_data = 4'h0;
    logic s_clear = 1'b0;
    logic s_locked;
    logic s_err;
    logic [3:0] s_cnt;

    int total = 0;
    int bad = 0;
    obs_t exp_q[$];

    lfsr_checker u_dut (
        .clk(clk),
        .reset(reset),
        .valid_i(valid_i),
        .data_i(data_i),
        .clear_i(clear_i),
        .locked_o(locked_o),
        .err_o(err_o),
        .err_count_o(err_count_o)
    );

    lfsr_checker #(
        .UNLOCK_COUNT(32),
        .CNT_W(4)
    ) u_sat (
        .clk(clk),
        .reset(s_reset),
        .valid_i(s_valid),
        .data_i(s_data),
        .clear_i(s_clear),
        .locked_o(s_locked),
        .err_o(s_err),
        .err_count_o(s_cnt)
    );

    task automatic drive(input logic v, input logic [3:0] d, input logic c);
        valid_i = v;
        data_i = d;
        clear_i = c;
    endtask

    task automatic push(input logic l, input logic e, input int c);
        exp_q.push_back({l, e, 16'(c)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        for (int i = 0; i < 2; i++) begin
            reset = 1'b0;
            drive(1'b1, 4'h1, 1'b0);
            push(1'b0, 1'b0, 0);
            tick();
            got = {locked_o, err_o, err_count_o};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset[%0d]: got l=%0b e=%0b c=%0d want l=%0b e=%0b c=%0d",
                         i, got.l, got.e, got.c, want.l, want.e, want.c);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_lock();
        obs_t got, want;
        logic [3:0] w [4] = '{4'h1, 4'h2, 4'h4, 4'h9};
        logic lk [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, w[i], 1'b0);
            push(lk[i], 1'b0, 0);
            tick();
            got = {locked_o, err_o, err_count_o};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL lock[%0d]: got l=%0b e=%0b c=%0d want l=%0b e=%0b c=%0d",
                         i, got.l, got.e, got.c, want.l, want.e, want.c);
            end
        end
    endtask

    task automatic test_single_err();
        obs_t got, want;
        logic [3:0] w [5] = '{4'h0, 4'h6, 4'hD, 4'hA, 4'h5};
        logic er [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, w[i], 1'b0);
            push(1'b1, er[i], 1);
            tick();
            got = {locked_o, err_o, err_count_o};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL single_err[%0d]: got l=%0b e=%0b c=%0d want l=%0b e=%0b c=%0d",
                         i, got.l, got.e, got.c, want.l, want.e, want.c);
            end
        end
    endtask

    task automatic test_unlock();
        obs_t got, want;
        logic v [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [3:0] w [10] = '{4'h3, 4'h0, 4'h0, 4'h0, 4'h0,
                               4'h1, 4'h2, 4'h4, 4'h9, 4'h0};
        logic c [10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        logic lk [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
        logic er [10] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        int cn [10] = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 4};
        for (int i = 0; i < 10; i++) begin
            drive(v[i], w[i], c[i]);
            push(lk[i], er[i], cn[i]);
            tick();
            got = {locked_o, err_o, err_count_o};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL unlock[%0d]: got l=%0b e=%0b c=%0d want l=%0b e=%0b c=%0d",
                         i, got.l, got.e, got.c, want.l, want.e, want.c);
            end
        end
    endtask

    task automatic test_gaps();
        obs_t got, want;
        logic r [20] = '{0, 1, 1, 1, 1, 1, 1, 1, 1,
                         0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        logic v [20] = '{1, 1, 0, 1, 0, 0, 1, 0, 1,
                         1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        logic [3:0] w [20] = '{4'h1, 4'h1, 4'hF, 4'h2, 4'h0, 4'h7, 4'h4, 4'h9, 4'h9,
                               4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                               4'h1, 4'h2, 4'h4, 4'h0, 4'h9};
        logic lk [20] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,
                          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 20; i++) begin
            reset = r[i];
            drive(v[i], w[i], 1'b0);
            push(lk[i], 1'b0, 0);
            tick();
            got = {locked_o, err_o, err_count_o};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL gaps[%0d]: got l=%0b e=%0b c=%0d want l=%0b e=%0b c=%0d",
                         i, got.l, got.e, got.c, want.l, want.e, want.c);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_reset_mid();
        obs_t got, want;
        logic r [14] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
        logic [3:0] w [14] = '{4'h1, 4'h1, 4'h2, 4'h4, 4'h9, 4'h0, 4'h0, 4'h0,
                               4'h0, 4'h1, 4'h2, 4'h4, 4'h9, 4'h0};
        logic lk [14] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
        logic er [14] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1};
        int cn [14] = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 14; i++) begin
            reset = r[i];
            drive(1'b1, w[i], 1'b0);
            push(lk[i], er[i], cn[i]);
            tick();
            got = {locked_o, err_o, err_count_o};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_mid[%0d]: got l=%0b e=%0b c=%0d want l=%0b e=%0b c=%0d",
                         i, got.l, got.e, got.c, want.l, want.e, want.c);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        obs_t got, want;
        logic v [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        logic [3:0] w [8] = '{4'h6, 4'h0, 4'h0, 4'h0, 4'hB, 4'h0, 4'h0, 4'h0};
        logic c [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        logic er [8] = '{0, 1, 1, 1, 0, 1, 1, 0};
        int cn [8] = '{1, 2, 3, 4, 4, 5, 0, 0};
        for (int i = 0; i < 8; i++) begin
            drive(v[i], w[i], c[i]);
            push(1'b1, er[i], cn[i]);
            tick();
            got = {locked_o, err_o, err_count_o};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got l=%0b e=%0b c=%0d want l=%0b e=%0b c=%0d",
                         i, got.l, got.e, got.c, want.l, want.e, want.c);
            end
        end
        drive(1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_saturation();
        obs_t got, want;
        logic [3:0] w [4] = '{4'h1, 4'h2, 4'h4, 4'h9};
        for (int i = 0; i < 27; i++) begin
            s_reset = (i != 0);
            s_clear = (i == 25);
            s_valid = (i != 26);
            s_data = (i >= 1 && i <= 4) ? w[i-1] : 4'h0;
            if (i == 0) push(1'b0, 1'b0, 0);
            else if (i <= 4) push(i == 4, 1'b0, 0);
            else if (i <= 24) push(1'b1, 1'b1, (i - 4 > 15) ? 15 : i - 4);
            else push(1'b1, i == 25, 0);
            tick();
            got = {s_locked, s_err, 12'h000, s_cnt};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL saturation[%0d]: got l=%0b e=%0b c=%0d want l=%0b e=%0b c=%0d",
                         i, got.l, got.e, got.c, want.l, want.e, want.c);
            end
        end
        s_valid = 1'b0;
        s_clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_err();
        test_unlock();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
